cmp_stream: RTL
===============

CMP_STREAM -- requirements
Module: cmp_stream

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of the sample and pass counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i0  input  W  operand A.
REQ-006 SHALL have port i1  input  W  operand B.
REQ-007 SHALL have port in_valid  input  1  marks i0/i1/mode as a sample this cycle.
REQ-008 SHALL have port mode  input  2  comparison select: 00 A==B, 01 A!=B, 10 A>B unsigned, 11 A<B unsigned.
REQ-009 SHALL have port clr  input  1  synchronous clear of counters, state and pipeline.
REQ-010 SHALL have port op  output  1  comparison result of the sample presented two cycles earlier.
REQ-011 SHALL have port out_valid  output  1  qualifies op.
REQ-012 SHALL have port total_cnt  output  CNT_W  number of completed samples.
REQ-013 SHALL have port pass_cnt  output  CNT_W  number of completed samples with op=1.
REQ-014 SHALL have port state  output  2  verdict: 00 IDLE, 01 PASS, 10 FAIL.

Function
REQ-015 SHALL be a two-stage pipeline. Stage 1 registers i0, i1 and mode, plus a valid bit equal to in_valid. Stage 2 registers op and out_valid from the stage-1 contents.
REQ-016 SHALL give a fixed latency of 2 cycles from an in_valid sample to out_valid; back-to-back samples every cycle SHALL be accepted with no stall.
REQ-017 SHALL hold op at its last value while out_valid=0.
REQ-018 SHALL perform all comparisons as unsigned on the full W bits.
REQ-019 SHALL, in the cycle after out_valid=1, increment total_cnt by 1, and increment pass_cnt by 1 when op=1.
REQ-020 SHALL saturate each counter at 2^CNT_W-1; saturation of one counter SHALL NOT stop the other.
REQ-021 SHALL implement the state FSM as follows:
- IDLE -> PASS on the first completed sample with op=1.
- IDLE -> FAIL on the first completed sample with op=0.
- PASS -> FAIL on any completed sample with op=0.
- FAIL is sticky until reset or clr.
- Encoding 11 is unreachable; it SHALL recover to IDLE on the next clock.
REQ-022 SHALL, when clr=1, clear both counters, set state to IDLE, and clear both pipeline valid bits on the next edge; an in_valid sample in the same cycle SHALL be discarded.
REQ-023 SHALL let clr override a counter increment or state transition scheduled in the same cycle.
REQ-024 SHALL apply mode per sample, so consecutive samples may use different modes.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, set op=0, out_valid=0, total_cnt=0, pass_cnt=0, state=IDLE, and clear all pipeline registers.
REQ-026 SHALL give reset priority over clr and in_valid.
REQ-027 SHALL, on reset asserted mid-stream, discard every in-flight sample so that none produces out_valid after reset deasserts.

Structure
REQ-028 SHALL place the mode encodings (MODE_EQ, MODE_NE, MODE_GT, MODE_LT) and state encodings (ST_IDLE, ST_PASS, ST_FAIL) in shared package cmp_pkg.
REQ-029 SHALL isolate the combinational compare in one sub-module, cmp_core (i0, i1, mode -> result), which the stage-2 register instantiates.

Verification
REQ-030 SHALL cover: with W=8, mode=00, samples (5,5),(5,6) on consecutive cycles -> op=1 then 0 at +2 cycles, total_cnt=2, pass_cnt=1, state IDLE->PASS->FAIL.
REQ-031 SHALL cover: mode=10 with (8'hFF,8'h01) then mode=11 with the same operands -> op=1 then 0, confirming unsigned compare and per-sample mode.
REQ-032 SHALL cover: CNT_W=4 with 20 passing samples -> total_cnt=pass_cnt=15 held, state=PASS.
REQ-033 SHALL cover: clr asserted while two samples are in flight, with in_valid=1 in the same cycle -> no out_valid afterwards, counters 0, state IDLE.
REQ-034 SHALL cover: reset pulsed one cycle after a sample -> out_valid stays 0 and all outputs read reset values.
REQ-035 SHALL cover: exhaustive W=2 sweep of all i0, i1, mode combinations (64 samples) -> op matches a reference model on every sample, total_cnt=64.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the streaming comparator: comparison modes and
// the verdict FSM states.
package cmp_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] state_t;

  localparam mode_t MODE_EQ = 2'b00;
  localparam mode_t MODE_NE = 2'b01;
  localparam mode_t MODE_GT = 2'b10;
  localparam mode_t MODE_LT = 2'b11;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_PASS = 2'b01;
  localparam state_t ST_FAIL = 2'b10;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational unsigned comparator; mode picks which relation
// between i0 and i1 is reported on result.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  mode_t        mode,
  output logic         result
);

  logic [W-1:0] diff_bits;
  logic         eq;
  logic         gt;
  logic         lt;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_diff
      assign diff_bits[gi] = i0[gi] ^ i1[gi];
    end
  endgenerate

  assign eq = ~|diff_bits;
  assign gt = i0 > i1;
  assign lt = i0 < i1;

  always_comb begin
    result = 1'b0;
    case (mode)
      MODE_EQ: result = eq;
      MODE_NE: result = ~eq;
      MODE_GT: result = gt;
      MODE_LT: result = lt;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_stream.sv
// Two-stage streaming comparator with saturating sample/pass counters and
// a sticky PASS/FAIL verdict over completed samples.
module cmp_stream
  import cmp_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     i0,
  input  logic [W-1:0]     i1,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             op,
  output logic             out_valid,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0]     s1_a_reg;
  logic [W-1:0]     s1_b_reg;
  mode_t            s1_mode_reg;
  logic             s1_valid_reg;
  logic             cmp_result;
  logic             op_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] total_cnt_reg;
  logic [CNT_W-1:0] pass_cnt_reg;
  state_t           state_reg;
  state_t           state_next;

  // Stage 1: operands are only reloaded on a real sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_mode_reg  <= MODE_EQ;
      s1_valid_reg <= 1'b0;
    end else if (clr) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_a_reg    <= i0;
        s1_b_reg    <= i1;
        s1_mode_reg <= mode;
      end
    end
  end

  cmp_core #(
    .W (W)
  ) u_cmp_core (
    .i0     (s1_a_reg),
    .i1     (s1_b_reg),
    .mode   (s1_mode_reg),
    .result (cmp_result)
  );

  // Stage 2: op holds its last value whenever no sample completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (clr) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        op_reg <= cmp_result;
      end
    end
  end

  // Counters account for the sample visible on op/out_valid during this cycle.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      total_cnt_reg <= '0;
      pass_cnt_reg  <= '0;
    end else if (out_valid_reg) begin
      if (total_cnt_reg != CNT_MAX) begin
        total_cnt_reg <= total_cnt_reg + CNT_W'(1);
      end
      if (op_reg && (pass_cnt_reg != CNT_MAX)) begin
        pass_cnt_reg <= pass_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (out_valid_reg) begin
          state_next = op_reg ? ST_PASS : ST_FAIL;
        end
      end
      ST_PASS: begin
        if (out_valid_reg && !op_reg) begin
          state_next = ST_FAIL;
        end
      end
      ST_FAIL: state_next = ST_FAIL;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    op        = op_reg;
    out_valid = out_valid_reg;
    total_cnt = total_cnt_reg;
    pass_cnt  = pass_cnt_reg;
    state     = state_reg;
  end

endmodule
